// File: rtl/xgriscv_fetch_queue_pkg.sv
// Shared constants for the xgriscv instruction-fetch front end.
package xgriscv_fetch_queue_pkg;

    localparam int          XLEN_DEF     = 32;
    localparam int          INSTR_SIZE   = 32;
    localparam int          ADDR_SIZE    = XLEN_DEF;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int          PC_STEP      = 4;

endpackage

// File: rtl/xgriscv_fetch_queue_if.sv
// Instruction-memory request/response bus between the fetch front end and imem.
interface xgriscv_fetch_queue_if
    import xgriscv_fetch_queue_pkg::*;
#(
    parameter int XLEN = ADDR_SIZE
) ();

    logic                  imem_req;
    logic [XLEN-1:0]       imem_addr;
    logic                  imem_gnt;
    logic                  imem_rvalid;
    logic [INSTR_SIZE-1:0] imem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata
    );

endinterface

// File: rtl/xgriscv_sync_fifo.sv
// Synchronous FIFO with registered head, flush, and simultaneous push/pop at any occupancy.
module xgriscv_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           head_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign count   = cnt;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    // NOTE: storage is not reset; validity lives entirely in cnt, so clearing the array buys nothing.
    always_ff @(posedge clk) begin
        if (reset && !flush && do_push) mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/xgriscv_fetch_queue.sv
// Fetch front end: PC generator, credit-limited request issue, stale-response drop and prefetch FIFO.
// Optional performance counters are built when XGRISCV_FETCH_PERF_EN is defined.
module xgriscv_fetch_queue
    import xgriscv_fetch_queue_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
    input  logic                    clk,
    input  logic                    reset,
    xgriscv_fetch_queue_if.master   imem,
    input  logic                    redirect,
    input  logic [XLEN-1:0]         redirect_pc,
    output logic                    instr_valid,
    output logic [INSTR_SIZE-1:0]   instr,
    output logic [XLEN-1:0]         instr_pc,
    input  logic                    id_ready,
    output logic [31:0]             perf_fetched,
    output logic [31:0]             perf_dropped
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int EW = INSTR_SIZE + XLEN;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     credit_used;
    logic            fifo_full;
    logic            fifo_empty;
    logic [EW-1:0]   fifo_head;
    logic [XLEN-1:0] target_pc;
    logic            issue;
    logic            resp;
    logic            discard;
    logic            push_ok;
    logic            pop;

    // Queued words plus words still in flight may never exceed the FIFO size.
    assign credit_used   = {1'b0, fifo_count} + {1'b0, outstanding};
    assign imem.imem_req  = reset && !redirect && (credit_used < (CW+1)'(DEPTH));
    assign imem.imem_addr = fetch_pc;

    assign issue     = imem.imem_req && imem.imem_gnt;
    assign resp      = imem.imem_rvalid;
    assign discard   = resp && (drop_cnt != '0);
    assign push_ok   = resp && !discard && !redirect && (!fifo_full || pop);
    assign pop       = instr_valid && id_ready;
    assign target_pc = {redirect_pc[XLEN-1:2], 2'b00};

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (redirect) begin
            // Everything still in flight after this edge belongs to the old path.
            fetch_pc    <= target_pc;
            resp_pc     <= target_pc;
            outstanding <= outstanding - CW'(resp);
            drop_cnt    <= outstanding - CW'(resp);
        end else begin
            if (issue)   fetch_pc <= fetch_pc + XLEN'(PC_STEP);
            if (push_ok) resp_pc  <= resp_pc + XLEN'(PC_STEP);
            if (discard) drop_cnt <= drop_cnt - CW'(1);
            outstanding <= outstanding + CW'(issue) - CW'(resp);
        end
    end

    xgriscv_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_ok),
        .push_data ({imem.imem_rdata, resp_pc}),
        .pop       (pop),
        .flush     (redirect),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Head fields read as zero whenever the queue is empty.
    assign instr_valid = !fifo_empty;
    assign instr       = instr_valid ? fifo_head[EW-1:XLEN] : '0;
    assign instr_pc    = instr_valid ? fifo_head[XLEN-1:0]  : '0;

`ifdef XGRISCV_FETCH_PERF_EN
    logic [31:0] fetched_q;
    logic [31:0] dropped_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetched_q <= '0;
            dropped_q <= '0;
        end else begin
            if (push_ok) fetched_q <= fetched_q + 32'd1;
            if (redirect)     dropped_q <= dropped_q + 32'(fifo_count) + 32'(resp);
            else if (discard) dropped_q <= dropped_q + 32'd1;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_dropped = dropped_q;
`else
    assign perf_fetched = '0;
    assign perf_dropped = '0;
`endif

endmodule

// File: tb/tb_xgriscv_fetch_queue.sv
// Randomised bench for xgriscv_fetch_queue: an in-order memory plus a queue-level reference of the fetch stream.
module tb_xgriscv_fetch_queue;
    import xgriscv_fetch_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_ready = 1'b0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] perf_fetched;
    logic [31:0] perf_dropped;

    xgriscv_fetch_queue_if #(.XLEN(XLEN)) imem ();

    xgriscv_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk          (clk),
        .reset        (reset),
        .imem         (imem),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .id_ready     (id_ready),
        .perf_fetched (perf_fetched),
        .perf_dropped (perf_dropped)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; bit stale; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;

    req_t        inflight[$];
    ent_t        fifo_m[$];
    logic [31:0] m_fetch_pc;
    int          m_fetched, m_dropped, m_issued, m_pops;
    int          cyc, lat_min, lat_max, obs_pops;
    int          tests, failed;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0013;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        inflight.delete();
        fifo_m.delete();
        m_fetch_pc = RESET_PC_DEF;
        m_fetched  = 0;
        m_dropped  = 0;
        m_issued   = 0;
        m_pops     = 0;
    endtask

    // One clock: drive inputs, compare outputs, then advance the reference to the next edge.
    task automatic step(input bit rst_lo, input bit redir, input logic [31:0] rpc,
                        input int gnt_pct, input bit idr);
        bit   resp, exp_req, grant, pop;
        req_t r;
        @(negedge clk);
        reset         = !rst_lo;
        redirect      = redir;
        redirect_pc   = rpc;
        id_ready      = idr;
        imem.imem_gnt = ($urandom_range(0, 99) < gnt_pct);
        resp          = !rst_lo && inflight.size() > 0 && inflight[0].due <= cyc;
        imem.imem_rvalid = resp;
        imem.imem_rdata  = resp ? mem_word(inflight[0].addr) : $urandom;
        #1;
        exp_req = !rst_lo && !redir && (fifo_m.size() + inflight.size() < DEPTH);
        check("imem_req", 32'(imem.imem_req), 32'(exp_req));
        if (exp_req) check("imem_addr", imem.imem_addr, m_fetch_pc);
        check("instr_valid", 32'(instr_valid), 32'(fifo_m.size() > 0));
        if (fifo_m.size() > 0) begin
            check("instr_pc", instr_pc, fifo_m[0].pc);
            check("instr", instr, fifo_m[0].data);
        end else begin
            check("instr_pc_idle", instr_pc, 32'h0);
            check("instr_idle", instr, 32'h0);
        end
`ifdef XGRISCV_FETCH_PERF_EN
        check("perf_fetched", perf_fetched, 32'(m_fetched));
        check("perf_dropped", perf_dropped, 32'(m_dropped));
`else
        check("perf_fetched_off", perf_fetched, 32'h0);
        check("perf_dropped_off", perf_dropped, 32'h0);
`endif
        if (instr_valid && idr) obs_pops++;
        grant = exp_req && imem.imem_gnt;
        pop   = fifo_m.size() > 0 && idr;

        if (rst_lo) begin
            model_reset();
        end else if (redir) begin
            m_dropped += fifo_m.size();
            fifo_m.delete();
            if (resp) begin
                void'(inflight.pop_front());
                m_dropped++;
            end
            foreach (inflight[i]) inflight[i].stale = 1'b1;
            m_fetch_pc = rpc & 32'hFFFF_FFFC;
        end else begin
            if (pop) begin
                void'(fifo_m.pop_front());
                m_pops++;
            end
            if (resp) begin
                r = inflight.pop_front();
                if (r.stale) begin
                    m_dropped++;
                end else begin
                    assert (fifo_m.size() < DEPTH) else begin
                        failed++;
                        $error("FAIL overflow: push onto a full queue at cycle %0d", cyc);
                    end
                    fifo_m.push_back('{r.addr, mem_word(r.addr)});
                    m_fetched++;
                end
            end
            if (grant) begin
                inflight.push_back('{m_fetch_pc, cyc + int'($urandom_range(lat_min, lat_max)), 1'b0});
                m_fetch_pc += 32'd4;
                m_issued++;
            end
        end
        cyc++;
    endtask

    // Stall decode until the reference holds a word, then compare the head PC after the edge.
    task automatic wait_head(input string tag, input logic [31:0] exp_pc, input int gnt_pct);
        int n = 0;
        while (fifo_m.size() == 0 && n < 40) begin
            step(1'b0, 1'b0, 32'h0, gnt_pct, 1'b0);
            n++;
        end
        @(posedge clk); #1;
        if (fifo_m.size() == 0) begin
            tests++;
            failed++;
            $error("FAIL %s: no word queued within bound, observed %h expected %h", tag, instr_pc, exp_pc);
        end else begin
            check(tag, instr_pc, exp_pc);
        end
    endtask

    initial begin
        int n;
        tests = 0; failed = 0; cyc = 0; obs_pops = 0;
        lat_min = 1; lat_max = 1;
        model_reset();
        imem.imem_gnt = 1'b0; imem.imem_rvalid = 1'b0; imem.imem_rdata = '0;
        repeat (2) @(posedge clk);

        // Reset state.
        repeat (2) step(1'b1, 1'b0, 32'h0, 100, 1'b1);

        // Steady fetch: one word per cycle once filled.
        obs_pops = 0;
        repeat (20) step(1'b0, 1'b0, 32'h0, 100, 1'b1);
        check("steady_pops", 32'(obs_pops), 32'd18);

        // Mid-run reset, then decode stall fills the queue and request drops.
        repeat (2) step(1'b1, 1'b0, 32'h0, 100, 1'b1);
        repeat (10) step(1'b0, 1'b0, 32'h0, 100, 1'b0);
        @(posedge clk); #1;
        check("stall_req_low", 32'(imem.imem_req), 32'h0);
        check("stall_head_pc", instr_pc, 32'h0);
        repeat (20) step(1'b0, 1'b0, 32'h0, 100, 1'b1);

        // Redirect with two or more responses in flight.
        lat_min = 3; lat_max = 3;
        n = 0;
        while (inflight.size() < 2 && n < 20) begin step(1'b0, 1'b0, 32'h0, 100, 1'b1); n++; end
        step(1'b0, 1'b1, 32'h0000_0100, 100, 1'b1);
        @(posedge clk); #1;
        check("redir_flush_valid", 32'(instr_valid), 32'h0);
        wait_head("redir_first_pc", 32'h0000_0100, 100);
        repeat (10) step(1'b0, 1'b0, 32'h0, 100, 1'b1);

        // Redirect in the same cycle as a response, with low bits set on the target.
        lat_min = 2; lat_max = 2;
        n = 0;
        while (!(inflight.size() >= 2 && inflight[0].due <= cyc) && n < 30) begin
            step(1'b0, 1'b0, 32'h0, 100, 1'b1); n++;
        end
        step(1'b0, 1'b1, 32'h0000_0203, 100, 1'b1);
        @(posedge clk); #1;
        check("redir_rvalid_valid", 32'(instr_valid), 32'h0);
        wait_head("redir_rvalid_pc", 32'h0000_0200, 100);
        repeat (10) step(1'b0, 1'b0, 32'h0, 100, 1'b1);

        // Grant backpressure and PC wrap.
        lat_min = 1; lat_max = 3;
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 30, 1'b0);
        wait_head("wrap_first_pc", 32'hFFFF_FFFC, 30);
        step(1'b0, 1'b0, 32'h0, 30, 1'b1);
        wait_head("wrap_second_pc", 32'h0000_0000, 30);
        repeat (60) step(1'b0, 1'b0, 32'h0, 30, ($urandom_range(0, 99) < 70));

        // Random traffic with occasional redirects.
        lat_min = 1; lat_max = 4;
        repeat (400) step(1'b0, ($urandom_range(0, 99) < 5), $urandom, 60, ($urandom_range(0, 99) < 70));

        // Counter scenario: 8 pushes, 5 pops, then a redirect clears the 3 remaining entries.
        lat_min = 1; lat_max = 1;
        repeat (2) step(1'b1, 1'b0, 32'h0, 100, 1'b0);
        n = 0;
        while (!(m_fetched == 8 && m_pops == 5) && n < 100) begin
            step(1'b0, 1'b0, 32'h0, (m_issued < 8) ? 100 : 0, (m_pops < 5));
            n++;
        end
        step(1'b0, 1'b1, 32'h0000_0300, 0, 1'b0);
        @(posedge clk); #1;
`ifdef XGRISCV_FETCH_PERF_EN
        check("perf_fetched_8", perf_fetched, 32'd8);
        check("perf_dropped_3", perf_dropped, 32'd3);
`else
        check("perf_fetched_tied", perf_fetched, 32'd0);
        check("perf_dropped_tied", perf_dropped, 32'd0);
`endif
        repeat (5) step(1'b0, 1'b0, 32'h0, 100, 1'b1);

        // Mid-run reset returns every output to zero.
        step(1'b1, 1'b0, 32'h0, 100, 1'b1);
        @(posedge clk); #1;
        check("rst_req", 32'(imem.imem_req), 32'h0);
        check("rst_valid", 32'(instr_valid), 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc", instr_pc, 32'h0);
        check("rst_perf_fetched", perf_fetched, 32'h0);
        check("rst_perf_dropped", perf_dropped, 32'h0);
        step(1'b0, 1'b0, 32'h0, 100, 1'b1);
        check("rst_first_addr", imem.imem_addr, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/xgriscv_fetch_queue.md
Name: xgriscv_fetch_queue

Overview:
- Parametrised instruction-fetch front end for the pipelined xgriscv core.
- Replaces the direct pc→imem→instr path with a PC generator, an outstanding-request tracker and a DEPTH-entry prefetch FIFO feeding decode.
- Supports variable-latency, in-order instruction memory.
- On branch/jump redirect, flushes the queue and discards stale in-flight responses.

Parameters:
- XLEN, 32: PC/address width.
- DEPTH, 4: prefetch FIFO entries; power of two, ≥2.
- RESET_PC, 32'h0000_0000: first fetch address after reset.

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- imem_req  output  1  fetch request valid.
- imem_addr  output  XLEN  fetch address; word-aligned.
- imem_gnt  input  1  request accepted this cycle when imem_req=1.
- imem_rvalid  input  1  response valid; responses return in request order.
- imem_rdata  input  32  instruction word.
- redirect  input  1  flush-and-redirect from EX (taken branch, jal, jalr).
- redirect_pc  input  XLEN  new fetch address.
- instr_valid  output  1  queue head valid.
- instr  output  32  queue head instruction.
- instr_pc  output  XLEN  PC of queue head.
- id_ready  input  1  decode accepts head; pop when instr_valid & id_ready.
- perf_fetched  output  32  see Optional Feature.
- perf_dropped  output  32  see Optional Feature.

Behaviour:
- **Reset** (reset=0 at posedge):
  - fetch_pc=RESET_PC; outstanding=0; drop_cnt=0; queue empty.
  - imem_req=0, instr_valid=0, instr=0, instr_pc=0; perf counters=0.
- **Issue:**
  - imem_req=1 iff not in reset, redirect=0, and occupancy+outstanding < DEPTH (credit rule).
  - imem_addr=fetch_pc (combinational from register).
  - On req&gnt: fetch_pc += 4 (wraps modulo 2^XLEN); outstanding += 1.
- **Response**, on imem_rvalid:
  - outstanding -= 1.
  - If drop_cnt>0: drop_cnt -= 1 and the word is discarded.
  - Otherwise push {imem_rdata, resp_pc}; resp_pc += 4.
- **Queue:**
  - Credit rule guarantees no overflow; a push on a full queue is a bench assertion failure.
  - Head is registered: a word pushed at edge N is visible at instr_valid no earlier than after edge N (one-cycle fill latency).
  - Simultaneous push and pop is allowed at any occupancy, including full and empty-with-bypass-forbidden.
- **Redirect** (highest priority):
  - At the edge: queue cleared; fetch_pc=resp_pc=redirect_pc.
  - drop_cnt = outstanding + (req&gnt this cycle? no — imem_req is 0 during redirect) − (imem_rvalid this cycle ? 1 : 0).
  - instr_valid=0 next cycle.
  - A pop in the redirect cycle has no further effect.
  - Issue resumes the cycle after the redirect.
- **Back-to-back redirects:** the last one wins; drop_cnt is recomputed each time.
- **Reset mid-operation:** all state returns to reset values. Responses to requests issued before reset are the memory's responsibility; memory is reset with the core.
- **Alignment:** redirect_pc[1:0] is forced to 0.
- **Steady-state throughput:** 1 instr/cycle when imem_gnt=1 and responses take ≤DEPTH−1 cycles.

Optional Feature:
- Macro XGRISCV_FETCH_PERF_EN.
- Defined:
  - perf_fetched increments on each push.
  - perf_dropped increments on each discarded response plus each valid entry cleared by redirect.
  - Both counters are 32-bit and wrap.
- Undefined: both outputs tied to 0 and no counter flops are generated.

Decomposition:
- Shared constants go in the existing defines include: `XLEN, `INSTR_SIZE, `ADDR_SIZE, and a new `RESET_PC default.
- One sub-module: xgriscv_sync_fifo.
  - Parameters WIDTH and DEPTH; push/pop/flush; full/empty/count.
  - Synchronous active-low reset.
  - Instantiated with WIDTH=32+XLEN.
- Credit, drop and PC logic stays in xgriscv_fetch_queue.

Test Plan:
- **Reset then steady fetch:** release reset, gnt=1, 1-cycle rvalid, id_ready=1 → imem_addr 0,4,8,…; instr_pc 0,4,8 on consecutive cycles once filled.
- **Decode stall:**
  - Stimulus: id_ready=0 for 10 cycles, DEPTH=4, 1-cycle latency.
  - Response: occupancy reaches 4 with outstanding=0; imem_req drops; the head holds PC 0 unchanged.
  - Release: PCs continue without gap or duplicate.
- **Redirect with in-flight responses:**
  - Stimulus: latency 3, 2 outstanding, redirect_pc=0x100.
  - Response: the next 2 rvalid words are discarded; the first instr_pc after redirect is 0x100.
- **Redirect coinciding with rvalid:** that word is discarded; drop_cnt = outstanding−1; no stale PC ever reaches instr.
- **Grant backpressure and PC wrap:**
  - Stimulus: random imem_gnt at 30%, redirect_pc=0xFFFF_FFFC.
  - Response: order preserved; PC sequence is 0xFFFF_FFFC then 0x0.
- **Perf counters and mid-run reset:**
  - With XGRISCV_FETCH_PERF_EN: after 8 pushes and a redirect dropping 3 entries, perf_fetched=8 and perf_dropped=3.
  - Reset mid-run: both counters and all outputs return to 0.
